// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset vector,
// the canonical nop and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Fetch PC register: async reset to the boot vector, redirect load with word
// alignment, and an enable for sequential advance.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_next,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  // A redirect outranks sequential advance; the low two target bits are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target & ~(XLEN'(3));
    end else if (i_en) begin
      r_pc <= i_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read at a time, redirect
// handling with stale-response dropping, and a valid/ready hand-off to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            id_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
);

  fetch_state_t    r_state;
  logic            r_instrValid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcInflight;

  logic [XLEN-1:0] w_fetchPc;
  logic [XLEN-1:0] w_nextPc;
  logic            w_issue;
  logic            w_rsp;

  assign w_issue  = (r_state == ST_REQ) && imem_gnt;
  assign w_rsp    = (r_state == ST_WAIT) && imem_rvalid;
  assign w_nextPc = r_pcInflight + XLEN'(4);

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (PCSrc),
    .i_target (PCTarget),
    .i_en     (w_rsp),
    .i_next   (w_nextPc),
    .o_pc     (w_fetchPc)
  );

  // The reset term keeps the request quiet while the FSM sits in its REQ reset state.
  assign imem_req    = (r_state == ST_REQ) && !rst;
  assign imem_addr   = w_fetchPc;
  assign instr_valid = r_instrValid;
  assign Instr       = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = r_pc + XLEN'(4);

  // A redirect flushes the presented instruction and decides whether a stale
  // response is still owed; otherwise responses go straight back to REQ when
  // decode is ready, so a fetch overlaps the hand-off of the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_instrValid <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pc         <= RESET_PC;
      r_pcInflight <= RESET_PC;
    end else begin
      if (w_issue) begin
        r_pcInflight <= w_fetchPc;
      end
      if (PCSrc) begin
        r_instrValid <= 1'b0;
        case (r_state)
          ST_REQ:  r_state <= imem_gnt ? ST_DROP : ST_REQ;
          ST_WAIT: r_state <= imem_rvalid ? ST_REQ : ST_DROP;
          ST_HOLD: r_state <= ST_REQ;
          default: r_state <= imem_rvalid ? ST_REQ : ST_DROP;
        endcase
      end else begin
        case (r_state)
          ST_REQ: begin
            if (r_instrValid && id_ready) begin
              r_instrValid <= 1'b0;
            end
            if (imem_gnt) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (r_instrValid && id_ready) begin
              r_instrValid <= 1'b0;
            end
            if (imem_rvalid) begin
              r_instr      <= imem_rdata;
              r_pc         <= r_pcInflight;
              r_instrValid <= 1'b1;
              r_state      <= id_ready ? ST_REQ : ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (id_ready) begin
              r_instrValid <= 1'b0;
              r_state      <= ST_REQ;
            end
          end
          default: begin
            if (imem_rvalid) begin
              r_state <= ST_REQ;
            end
          end
        endcase
      end
    end
  end

endmodule
